// File: rtl/serial_io_pkg.sv
// Shared types for the serial I/O sequencer: command codes,
// FSM states and STATUS word bit positions.
package serial_io_pkg;

  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_WRITE  = 3'd1,
    CMD_READ   = 3'd2,
    CMD_STATUS = 3'd3,
    CMD_CLEAR  = 3'd4
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TX_WAIT,
    S_TX_PUSH,
    S_RX_WAIT,
    S_RX_POP,
    S_RX_LAT,
    S_FINISH
  } state_e;

  localparam int ST_TX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_ERR_TX   = 4;
  localparam int ST_ERR_RX   = 5;

  localparam logic [15:0] RX_TIMEOUT_WORD = 16'h00FF;

  function automatic logic [15:0] status_word(
    input logic err_rx,
    input logic err_tx,
    input logic rx_empty,
    input logic tx_full
  );
    logic [15:0] w;
    w = '0;
    w[ST_ERR_RX]   = err_rx;
    w[ST_ERR_TX]   = err_tx;
    w[ST_RX_EMPTY] = rx_empty;
    w[ST_TX_FULL]  = tx_full;
    return w;
  endfunction

endpackage

// File: rtl/serial_io_sequencer_if.sv
// Command/status and FIFO strobe bundle of the sequencer.
// slave: sequencer side; master: CPU decoder + FIFO side.
interface serial_io_sequencer_if;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       bus_read;
  logic       busy;
  logic       done;
  logic [7:0] tx_data;
  logic       tx_write;
  logic       tx_full;
  logic [7:0] rx_data;
  logic       rx_read;
  logic       rx_empty;

  modport slave (
    input  cmd, cmd_valid, bus_read,
    input  tx_full, rx_data, rx_empty,
    output busy, done, tx_data,
    output tx_write, rx_read
  );

  modport master (
    output cmd, cmd_valid, bus_read,
    output tx_full, rx_data, rx_empty,
    input  busy, done, tx_data,
    input  tx_write, rx_read
  );
endinterface

// File: rtl/sio_wait_timer.sv
// Bounded wait counter shared by the TX and RX wait states.
// Ports: clock, reset, i_load (clear), i_en (count), o_expired.
module sio_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW =
    (TIMEOUT_CYCLES < 256) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit NEVER = (TIMEOUT_CYCLES == 0);
  localparam logic [CW-1:0] LIMIT =
    NEVER ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clock) begin
    if (reset || i_load) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires in the wait cycle that brings the count to the limit.
  assign o_expired = !NEVER && i_en && (r_cnt == LIMIT);

endmodule

// File: rtl/serial_io_sequencer.sv
// Sequences CPU byte commands onto the serial TX/RX FIFO pair.
// Ports: clock, reset, bus (shared inout), sio (slave bundle).
module serial_io_sequencer
  import serial_io_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int RD_LATENCY     = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  inout  wire  [15:0]           bus,
  serial_io_sequencer_if.slave  sio
);

  localparam logic [1:0] LAT = 2'(RD_LATENCY);

  state_e      r_state;
  logic [15:0] r_result;
  logic [7:0]  r_tx_data;
  logic [1:0]  r_lat;
  logic        r_busy;
  logic        r_done;
  logic        r_tx_write;
  logic        r_rx_read;
  logic        r_err_tx;
  logic        r_err_rx;

  logic w_tx_wait;
  logic w_rx_wait;
  logic w_tmr_load;
  logic w_tmr_en;
  logic w_expired;
  logic w_is_wr;
  logic w_is_rd;
  logic w_is_st;
  logic w_is_clr;

  assign w_tx_wait = (r_state == S_TX_WAIT);
  assign w_rx_wait = (r_state == S_RX_WAIT);

  // Count is held at zero outside the wait states.
  assign w_tmr_load = !(w_tx_wait || w_rx_wait);
  assign w_tmr_en   = (w_tx_wait && sio.tx_full)
                   || (w_rx_wait && sio.rx_empty);

  assign w_is_wr  = (sio.cmd == CMD_WRITE);
  assign w_is_rd  = (sio.cmd == CMD_READ);
  assign w_is_st  = (sio.cmd == CMD_STATUS);
  assign w_is_clr = (sio.cmd == CMD_CLEAR);

  sio_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .i_load    (w_tmr_load),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_tx_data  <= '0;
      r_lat      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_tx_write <= 1'b0;
      r_rx_read  <= 1'b0;
      r_err_tx   <= 1'b0;
      r_err_rx   <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_tx_write <= 1'b0;
      r_rx_read  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (sio.cmd_valid) begin
            unique case (1'b1)
              w_is_wr: begin
                r_tx_data <= bus[7:0];
                r_busy    <= 1'b1;
                r_state   <= S_TX_WAIT;
              end
              w_is_rd: begin
                r_busy  <= 1'b1;
                r_state <= S_RX_WAIT;
              end
              w_is_st: begin
                r_result <= status_word(
                  r_err_rx, r_err_tx,
                  sio.rx_empty, sio.tx_full);
                r_busy  <= 1'b1;
                r_done  <= 1'b1;
                r_state <= S_FINISH;
              end
              w_is_clr: begin
                r_err_tx <= 1'b0;
                r_err_rx <= 1'b0;
                r_busy   <= 1'b1;
                r_done   <= 1'b1;
                r_state  <= S_FINISH;
              end
              default: ;
            endcase
          end
        end
        S_TX_WAIT: begin
          if (!sio.tx_full) begin
            r_tx_write <= 1'b1;
            r_state    <= S_TX_PUSH;
          end else if (w_expired) begin
            r_err_tx <= 1'b1;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end
        end
        S_TX_PUSH: begin
          r_done  <= 1'b1;
          r_state <= S_FINISH;
        end
        S_RX_WAIT: begin
          if (!sio.rx_empty) begin
            r_rx_read <= 1'b1;
            r_state   <= S_RX_POP;
          end else if (w_expired) begin
            r_err_rx <= 1'b1;
            r_result <= RX_TIMEOUT_WORD;
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end
        end
        S_RX_POP: begin
          r_lat   <= 2'd1;
          r_state <= S_RX_LAT;
        end
        S_RX_LAT: begin
          // rx_data is valid in the LAT-th cycle after the pop.
          if (r_lat == LAT) begin
            r_result <= {8'h00, sio.rx_data};
            r_done   <= 1'b1;
            r_state  <= S_FINISH;
          end else begin
            r_lat <= r_lat + 2'd1;
          end
        end
        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sio.busy     = r_busy;
  assign sio.done     = r_done;
  assign sio.tx_data  = r_tx_data;
  assign sio.tx_write = r_tx_write;
  assign sio.rx_read  = r_rx_read;

  assign bus = sio.bus_read ? r_result : 16'bz;

endmodule

// File: tb/tb_serial_io_sequencer.sv
// Scoreboard bench for serial_io_sequencer.
// DUT a: default timeouts; DUT b: TIMEOUT 8, RD_LATENCY 3.
module tb_serial_io_sequencer;
  import serial_io_pkg::*;

  localparam int EV_TX   = 0;
  localparam int EV_RX   = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    bit         dut;
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  cmd;
  logic        cv_a;
  logic        cv_b;
  logic        bus_read;
  logic        tx_full;
  logic        rx_empty;
  logic [7:0]  rx_data;
  logic        bus_oe;
  logic [15:0] bus_drv;
  wire  [15:0] bus_a;
  wire  [15:0] bus_b;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_on = 0;
  ev_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus_a = bus_oe ? bus_drv : 16'bz;
  assign bus_b = bus_oe ? bus_drv : 16'bz;

  serial_io_sequencer_if ifa ();
  serial_io_sequencer_if ifb ();

  assign ifa.cmd       = cmd;
  assign ifa.cmd_valid = cv_a;
  assign ifa.bus_read  = bus_read;
  assign ifa.tx_full   = tx_full;
  assign ifa.rx_data   = rx_data;
  assign ifa.rx_empty  = rx_empty;
  assign ifb.cmd       = cmd;
  assign ifb.cmd_valid = cv_b;
  assign ifb.bus_read  = bus_read;
  assign ifb.tx_full   = tx_full;
  assign ifb.rx_data   = rx_data;
  assign ifb.rx_empty  = rx_empty;

  serial_io_sequencer #(
    .TIMEOUT_CYCLES(255),
    .RD_LATENCY    (1)
  ) u_a (
    .clock (clk),
    .reset (rst),
    .bus   (bus_a),
    .sio   (ifa)
  );

  serial_io_sequencer #(
    .TIMEOUT_CYCLES(8),
    .RD_LATENCY    (3)
  ) u_b (
    .clock (clk),
    .reset (rst),
    .bus   (bus_b),
    .sio   (ifb)
  );

  task automatic check(input string nm,
                       input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h",
               nm, act, exp);
    end
  endtask

  task automatic expect_ev(input bit d, input int k,
                           input logic [7:0] data,
                           input int c);
    ev_t e;
    e.dut  = d;
    e.kind = k;
    e.data = data;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic observe(input bit d, input int k,
                         input logic [7:0] data);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL stray_strobe: got dut=%0d kind=%0d cyc=%0d, required none",
               d, k, cyc);
    end else begin
      e = sb.pop_front();
      if (e.dut != d || e.kind != k || e.cyc != cyc
          || (k == EV_TX && e.data != data)) begin
        failures++;
        $display("FAIL strobe: got dut=%0d kind=%0d cyc=%0d data=%h, required dut=%0d kind=%0d cyc=%0d data=%h",
                 d, k, cyc, data, e.dut, e.kind, e.cyc, e.data);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (ifa.tx_write) begin
          check("a_push_full", 16'(tx_full), 16'h0);
          observe(0, EV_TX, ifa.tx_data);
        end
        if (ifa.rx_read) begin
          check("a_pop_empty", 16'(rx_empty), 16'h0);
          observe(0, EV_RX, 8'h00);
        end
        if (ifa.done) observe(0, EV_DONE, 8'h00);
        if (ifb.tx_write) begin
          check("b_push_full", 16'(tx_full), 16'h0);
          observe(1, EV_TX, ifb.tx_data);
        end
        if (ifb.rx_read) begin
          check("b_pop_empty", 16'(rx_empty), 16'h0);
          observe(1, EV_RX, 8'h00);
        end
        if (ifb.done) observe(1, EV_DONE, 8'h00);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit d, input logic [2:0] c,
                       input logic [15:0] data,
                       output int a);
    cmd     = c;
    bus_drv = data;
    bus_oe  = 1'b1;
    cv_a    = !d;
    cv_b    = d;
    a       = cyc;
    tick();
    cv_a   = 1'b0;
    cv_b   = 1'b0;
    bus_oe = 1'b0;
  endtask

  task automatic rd_bus(input bit d,
                        input logic [15:0] exp,
                        input string nm);
    bus_read = 1'b1;
    #1;
    check(nm, d ? bus_b : bus_a, exp);
    bus_read = 1'b0;
    #1;
  endtask

  task automatic wait_idle(input bit d, input string nm);
    int n;
    n = 0;
    while ((d ? ifb.busy : ifa.busy) && n < 400) begin
      tick();
      n++;
    end
    check({nm, "_idle"},
          16'(d ? ifb.busy : ifa.busy), 16'h0);
    check({nm, "_drained"}, 16'(sb.size()), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a;
    rst      = 1'b1;
    cmd      = 3'd0;
    cv_a     = 1'b0;
    cv_b     = 1'b0;
    bus_read = 1'b0;
    tx_full  = 1'b0;
    rx_empty = 1'b1;
    rx_data  = 8'h00;
    bus_oe   = 1'b0;
    bus_drv  = 16'h0;
    repeat (3) tick();
    check("rst_busy_a", 16'(ifa.busy), 16'h0);
    check("rst_busy_b", 16'(ifb.busy), 16'h0);
    check("rst_done_a", 16'(ifa.done), 16'h0);
    check("rst_txw_a", 16'(ifa.tx_write), 16'h0);
    check("rst_rxr_a", 16'(ifa.rx_read), 16'h0);
    check("rst_txd_a", 16'(ifa.tx_data), 16'h0);
    rd_bus(0, 16'h0000, "rst_result_a");
    rst    = 1'b0;
    mon_on = 1'b1;
    tick();

    // plain write
    issue(0, CMD_WRITE, 16'h12A5, a);
    expect_ev(0, EV_TX, 8'hA5, a + 2);
    expect_ev(0, EV_DONE, 8'h00, a + 3);
    check("wr_busy", 16'(ifa.busy), 16'h1);
    wait_idle(0, "wr");
    check("wr_txd", 16'(ifa.tx_data), 16'h00A5);

    // write stalled by tx_full for 10 cycles
    tx_full = 1'b1;
    issue(0, CMD_WRITE, 16'h0077, a);
    expect_ev(0, EV_TX, 8'h77, a + 12);
    expect_ev(0, EV_DONE, 8'h00, a + 13);
    repeat (10) tick();
    tx_full = 1'b0;
    wait_idle(0, "wrfull");
    issue(0, CMD_STATUS, 16'h0, a);
    expect_ev(0, EV_DONE, 8'h00, a + 1);
    wait_idle(0, "st1");
    rd_bus(0, 16'h0008, "st_no_err_tx");

    // read, latency 1, bus_read mid-command
    rx_empty = 1'b0;
    rx_data  = 8'h3C;
    issue(0, CMD_READ, 16'h0, a);
    expect_ev(0, EV_RX, 8'h00, a + 2);
    expect_ev(0, EV_DONE, 8'h00, a + 4);
    rd_bus(0, 16'h0008, "bus_mid_read");
    tick();
    tick();
    rx_empty = 1'b0;
    rx_empty = 1'b1;
    wait_idle(0, "rd");
    rd_bus(0, 16'h003C, "rd_result");

    // read, latency 3 on dut b
    rx_empty = 1'b0;
    rx_data  = 8'hEE;
    issue(1, CMD_READ, 16'h0, a);
    expect_ev(1, EV_RX, 8'h00, a + 2);
    expect_ev(1, EV_DONE, 8'h00, a + 6);
    tick();
    tick();
    rx_empty = 1'b1;
    tick();
    tick();
    rx_data = 8'h5D;
    tick();
    rx_data = 8'hEE;
    wait_idle(1, "lat3");
    rd_bus(1, 16'h005D, "lat3_result");

    // rx timeout after 8 waits, status, clear
    issue(1, CMD_READ, 16'h0, a);
    expect_ev(1, EV_DONE, 8'h00, a + 9);
    wait_idle(1, "rxto");
    rd_bus(1, 16'h00FF, "rxto_result");
    issue(1, CMD_STATUS, 16'h0, a);
    expect_ev(1, EV_DONE, 8'h00, a + 1);
    wait_idle(1, "st2");
    rd_bus(1, 16'h0028, "st_err_rx");
    issue(1, CMD_CLEAR, 16'h0, a);
    expect_ev(1, EV_DONE, 8'h00, a + 1);
    wait_idle(1, "clr");
    issue(1, CMD_STATUS, 16'h0, a);
    expect_ev(1, EV_DONE, 8'h00, a + 1);
    wait_idle(1, "st3");
    rd_bus(1, 16'h0008, "st_cleared");

    // cmd_valid while busy is dropped
    issue(0, CMD_WRITE, 16'h0011, a);
    expect_ev(0, EV_TX, 8'h11, a + 2);
    expect_ev(0, EV_DONE, 8'h00, a + 3);
    cmd     = CMD_WRITE;
    bus_drv = 16'h0099;
    bus_oe  = 1'b1;
    cv_a    = 1'b1;
    repeat (3) tick();
    cv_a   = 1'b0;
    bus_oe = 1'b0;
    tick();
    tick();
    check("busy_ignored", 16'(ifa.busy), 16'h0);
    check("txd_kept", 16'(ifa.tx_data), 16'h0011);
    check("ign_drained", 16'(sb.size()), 16'h0);

    // reset while in TX_WAIT
    tx_full = 1'b1;
    issue(0, CMD_WRITE, 16'h00BB, a);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_tx_busy", 16'(ifa.busy), 16'h0);
    tx_full = 1'b0;
    repeat (4) tick();
    check("rst_tx_stay", 16'(ifa.busy), 16'h0);
    check("rst_tx_txd", 16'(ifa.tx_data), 16'h0);
    rd_bus(0, 16'h0000, "rst_tx_result");
    bus_drv = 16'hC33C;
    bus_oe  = 1'b1;
    #1;
    check("bus_released", bus_a, 16'hC33C);
    bus_oe = 1'b0;

    // reset while in RX_LAT
    tick();
    rx_empty = 1'b0;
    rx_data  = 8'h44;
    issue(0, CMD_READ, 16'h0, a);
    expect_ev(0, EV_RX, 8'h00, a + 2);
    tick();
    tick();
    rst      = 1'b1;
    rx_empty = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_rx_busy", 16'(ifa.busy), 16'h0);
    rd_bus(0, 16'h0000, "rst_rx_result");
    repeat (3) tick();
    check("rst_rx_drained", 16'(sb.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
